// File: rtl/vga_fml_arbiter_pkg.sv
// Shared types and constants for the VGA frame-buffer FML arbiter.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DISP,
      CPU,
      ACK
   } arb_state_e;

   localparam logic [24:0] FB_BASE_DEF = 25'h00B8000;
   localparam logic [15:0] ABORT_DATA  = 16'hFFFF;

endpackage

// File: rtl/vga_fml_arbiter_if.sv
// FML (SDRAM) single-port bus: the arbiter drives it as master, the memory answers as slave.
interface vga_fml_arbiter_if #(
   parameter int unsigned FML_DEPTH = 25
);
   logic [FML_DEPTH-1:0] adr;
   logic                 stb;
   logic                 we;
   logic [1:0]           sel;
   logic [15:0]          dat_w;
   logic [15:0]          dat_r;
   logic                 ack;

   modport master (
      output adr, stb, we, sel, dat_w,
      input  dat_r, ack
   );

   modport slave (
      input  adr, stb, we, sel, dat_w,
      output dat_r, ack
   );
endinterface

// File: rtl/vga_fml_arbiter.sv
// Shares one FML port between display fetch (priority) and CPU, with a CPU
// starvation guard and a per-transaction watchdog on fml ack.
module vga_fml_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned          fml_depth      = 25,
   parameter logic [fml_depth-1:0] FB_BASE        = fml_depth'(FB_BASE_DEF),
   parameter int unsigned          MAX_DISP_BURST = 4,
   parameter int unsigned          TIMEOUT        = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 disp_stb_i,
   input  logic [17:1]          disp_adr_i,
   output logic [15:0]          disp_dat_o,
   output logic                 disp_ack_o,
   input  logic                 cpu_stb_i,
   input  logic                 cpu_we_i,
   input  logic [17:1]          cpu_adr_i,
   input  logic [1:0]           cpu_sel_i,
   input  logic [15:0]          cpu_dat_i,
   output logic [15:0]          cpu_dat_o,
   output logic                 cpu_ack_o,
   vga_fml_arbiter_if.master    fml,
   output logic                 err_o
);

   arb_state_e           state_q;
   logic [7:0]           starve_q;
   logic [7:0]           wd_q;
   logic [7:0]           wd_d;
   logic [fml_depth-1:0] fml_adr_q;
   logic                 fml_stb_q;
   logic                 fml_we_q;
   logic [1:0]           fml_sel_q;
   logic [15:0]          fml_do_q;
   logic [15:0]          disp_dat_q;
   logic                 disp_ack_q;
   logic [15:0]          cpu_dat_q;
   logic                 cpu_ack_q;
   logic                 err_q;

   logic [fml_depth-1:0] disp_fml_adr;
   logic [fml_depth-1:0] cpu_fml_adr;
   logic                 grant_disp;
   logic                 grant_cpu;
   logic                 timeout_hit;

   always_comb begin
      disp_fml_adr = FB_BASE + fml_depth'({disp_adr_i, 1'b0});
      cpu_fml_adr  = FB_BASE + fml_depth'({cpu_adr_i, 1'b0});
      grant_disp   = disp_stb_i && (!cpu_stb_i || (starve_q < 8'(MAX_DISP_BURST)));
      grant_cpu    = !grant_disp && cpu_stb_i;
      wd_d         = wd_q + 8'd1;
      timeout_hit  = (wd_d == 8'(TIMEOUT));
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         wd_q       <= '0;
         fml_adr_q  <= '0;
         fml_stb_q  <= 1'b0;
         fml_we_q   <= 1'b0;
         fml_sel_q  <= '0;
         fml_do_q   <= '0;
         disp_dat_q <= '0;
         disp_ack_q <= 1'b0;
         cpu_dat_q  <= '0;
         cpu_ack_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!cpu_stb_i) starve_q <= '0;
               if (grant_disp) begin
                  state_q   <= DISP;
                  fml_adr_q <= disp_fml_adr;
                  fml_stb_q <= 1'b1;
                  fml_we_q  <= 1'b0;
                  fml_sel_q <= 2'b11;
                  fml_do_q  <= '0;
                  wd_q      <= '0;
                  // grant_disp with a waiting CPU implies starve_q < MAX, so this saturates
                  if (cpu_stb_i) starve_q <= starve_q + 8'd1;
               end else if (grant_cpu) begin
                  state_q   <= CPU;
                  fml_adr_q <= cpu_fml_adr;
                  fml_stb_q <= 1'b1;
                  fml_we_q  <= cpu_we_i;
                  fml_sel_q <= cpu_sel_i;
                  fml_do_q  <= cpu_dat_i;
                  wd_q      <= '0;
                  starve_q  <= '0;
               end
            end

            DISP, CPU: begin
               if (fml.ack) begin
                  fml_stb_q <= 1'b0;
                  state_q   <= ACK;
                  if (state_q == DISP) begin
                     disp_dat_q <= fml.dat_r;
                     disp_ack_q <= 1'b1;
                  end else begin
                     if (!fml_we_q) cpu_dat_q <= fml.dat_r;
                     cpu_ack_q <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  fml_stb_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= ACK;
                  if (state_q == DISP) begin
                     disp_dat_q <= ABORT_DATA;
                     disp_ack_q <= 1'b1;
                  end else begin
                     cpu_dat_q <= ABORT_DATA;
                     cpu_ack_q <= 1'b1;
                  end
               end else begin
                  wd_q <= wd_d;
               end
            end

            ACK: begin
               disp_ack_q <= 1'b0;
               cpu_ack_q  <= 1'b0;
               err_q      <= 1'b0;
               state_q    <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign fml.adr    = fml_adr_q;
   assign fml.stb    = fml_stb_q;
   assign fml.we     = fml_we_q;
   assign fml.sel    = fml_sel_q;
   assign fml.dat_w  = fml_do_q;
   assign disp_dat_o = disp_dat_q;
   assign disp_ack_o = disp_ack_q;
   assign cpu_dat_o  = cpu_dat_q;
   assign cpu_ack_o  = cpu_ack_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_vga_fml_arbiter.sv
// Scoreboard bench for vga_fml_arbiter: requesters push expectations, monitors check FML grants and acks.
module tb_vga_fml_arbiter;

   typedef struct {
      logic [24:0] adr;
      logic        we;
      logic [1:0]  sel;
      logic [15:0] dw;
      int unsigned dur;
   } fml_exp_t;

   typedef struct {
      logic [15:0] dat;
      logic        err;
   } rsp_exp_t;

   logic        wb_clk;
   logic        wb_rst_n;
   logic        disp_stb;
   logic [17:1] disp_adr;
   logic [15:0] disp_dat;
   logic        disp_ack;
   logic        cpu_stb;
   logic        cpu_we;
   logic [17:1] cpu_adr;
   logic [1:0]  cpu_sel;
   logic [15:0] cpu_dw;
   logic [15:0] cpu_dr;
   logic        cpu_ack;
   logic        err;

   vga_fml_arbiter_if #(.FML_DEPTH(25)) fml_bus ();

   vga_fml_arbiter #(
      .fml_depth      (25),
      .FB_BASE        (25'h00B8000),
      .MAX_DISP_BURST (4),
      .TIMEOUT        (8)
   ) dut (
      .wb_clk_i   (wb_clk),
      .wb_rst_ni  (wb_rst_n),
      .disp_stb_i (disp_stb),
      .disp_adr_i (disp_adr),
      .disp_dat_o (disp_dat),
      .disp_ack_o (disp_ack),
      .cpu_stb_i  (cpu_stb),
      .cpu_we_i   (cpu_we),
      .cpu_adr_i  (cpu_adr),
      .cpu_sel_i  (cpu_sel),
      .cpu_dat_i  (cpu_dw),
      .cpu_dat_o  (cpu_dr),
      .cpu_ack_o  (cpu_ack),
      .fml        (fml_bus.master),
      .err_o      (err)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   fml_exp_t q_fml_d[$];
   fml_exp_t q_fml_c[$];
   rsp_exp_t q_rsp_d[$];
   rsp_exp_t q_rsp_c[$];
   byte      grant_log[$];

   int unsigned slv_lat   = 3;
   bit          slv_fixed = 1'b1;
   logic [15:0] slv_data  = 16'h0000;

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [24:0] byte_adr(input logic [16:0] a);
      return 25'h00B8000 + {7'h0, a, 1'b0};
   endfunction

   // FML slave: acks after slv_lat cycles of stb (never when slv_lat == 0)
   initial begin
      int unsigned cnt;
      cnt = 0;
      fml_bus.ack   = 1'b0;
      fml_bus.dat_r = 16'h0000;
      forever begin
         @(negedge wb_clk);
         if (!fml_bus.stb) begin
            cnt = 0;
            fml_bus.ack = 1'b0;
         end else if (fml_bus.ack) begin
            fml_bus.ack = 1'b0;
         end else begin
            cnt++;
            if (slv_lat != 0 && cnt == slv_lat) begin
               fml_bus.ack   = 1'b1;
               fml_bus.dat_r = slv_fixed ? slv_data : (fml_bus.adr[15:0] ^ 16'h5A5A);
            end
         end
      end
   end

   // FML monitor: checks each grant, its stability and its strobe duration
   initial begin
      bit          in_txn;
      int unsigned cnt;
      int unsigned cur_dur;
      fml_exp_t    e;
      fml_exp_t    cap;
      bit          is_cpu;
      in_txn = 0;
      cnt = 0;
      cur_dur = 0;
      forever begin
         @(negedge wb_clk);
         if (!wb_rst_n) begin
            in_txn = 0;
            cnt = 0;
         end else if (fml_bus.stb) begin
            if (!in_txn) begin
               in_txn = 1;
               cnt = 0;
               is_cpu = fml_bus.we || (fml_bus.sel != 2'b11);
               grant_log.push_back(is_cpu ? 8'h43 : 8'h44);
               cap = '{fml_bus.adr, fml_bus.we, fml_bus.sel, fml_bus.dat_w, 0};
               checks++;
               if ((is_cpu && q_fml_c.size() == 0) || (!is_cpu && q_fml_d.size() == 0)) begin
                  errors++;
                  $display("FAIL unexpected_grant: got adr %h we %b sel %b, required no grant",
                           fml_bus.adr, fml_bus.we, fml_bus.sel);
                  cur_dur = 0;
               end else begin
                  e = is_cpu ? q_fml_c.pop_front() : q_fml_d.pop_front();
                  cur_dur = e.dur;
                  chk("fml_adr", 32'(fml_bus.adr), 32'(e.adr));
                  chk("fml_we", 32'(fml_bus.we), 32'(e.we));
                  chk("fml_sel", 32'(fml_bus.sel), 32'(e.sel));
                  chk("fml_do", 32'(fml_bus.dat_w), 32'(e.dw));
               end
            end else begin
               chk("fml_stable", {fml_bus.adr, fml_bus.we, fml_bus.sel, 4'h0},
                   {cap.adr, cap.we, cap.sel, 4'h0});
            end
            cnt++;
         end else if (in_txn) begin
            in_txn = 0;
            if (cur_dur != 0) chk("fml_stb_cycles", cnt, cur_dur);
         end
      end
   end

   // Response monitor: pops expected data/err on every ack
   initial begin
      rsp_exp_t r;
      forever begin
         @(negedge wb_clk);
         if (wb_rst_n) begin
            if (disp_ack && cpu_ack) begin
               checks++; errors++;
               $display("FAIL dual_ack: got both acks, required at most one");
            end
            if (err && !disp_ack && !cpu_ack) begin
               checks++; errors++;
               $display("FAIL err_without_ack: got err_o=1 with no ack, required err_o=0");
            end
            if (disp_ack) begin
               if (q_rsp_d.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_disp_ack: got disp_ack_o=1, required 0");
               end else begin
                  r = q_rsp_d.pop_front();
                  chk("disp_dat", 32'(disp_dat), 32'(r.dat));
                  chk("disp_err", 32'(err), 32'(r.err));
               end
            end
            if (cpu_ack) begin
               if (q_rsp_c.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_cpu_ack: got cpu_ack_o=1, required 0");
               end else begin
                  r = q_rsp_c.pop_front();
                  chk("cpu_dat", 32'(cpu_dr), 32'(r.dat));
                  chk("cpu_err", 32'(err), 32'(r.err));
               end
            end
         end
      end
   end

   task automatic disp_req(input logic [16:0] a, input logic [24:0] eadr,
                           input logic [15:0] edat, input logic eerr, input int unsigned dur);
      bit got;
      q_fml_d.push_back('{eadr, 1'b0, 2'b11, 16'h0000, dur});
      q_rsp_d.push_back('{edat, eerr});
      disp_adr = a;
      disp_stb = 1'b1;
      got = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(posedge wb_clk); #1;
         got = disp_ack;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL disp_ack_timeout: got no disp_ack_o in 60 cycles, required an ack");
      end
      disp_stb = 1'b0;
      @(posedge wb_clk); #1;
   endtask

   task automatic cpu_req(input logic [16:0] a, input logic we, input logic [1:0] sel,
                          input logic [15:0] dw, input logic [24:0] eadr,
                          input logic [15:0] edat, input int unsigned dur);
      bit got;
      q_fml_c.push_back('{eadr, we, sel, dw, dur});
      q_rsp_c.push_back('{edat, 1'b0});
      cpu_adr = a;
      cpu_we  = we;
      cpu_sel = sel;
      cpu_dw  = dw;
      cpu_stb = 1'b1;
      got = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(posedge wb_clk); #1;
         got = cpu_ack;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL cpu_ack_timeout: got no cpu_ack_o in 60 cycles, required an ack");
      end
      cpu_stb = 1'b0;
      @(posedge wb_clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_disp_ack"}, 32'(disp_ack), 32'h0);
      chk({tag, "_disp_dat"}, 32'(disp_dat), 32'h0);
      chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'h0);
      chk({tag, "_cpu_dat"}, 32'(cpu_dr), 32'h0);
      chk({tag, "_fml_adr"}, 32'(fml_bus.adr), 32'h0);
      chk({tag, "_fml_ctl"}, {28'h0, fml_bus.stb, fml_bus.we, fml_bus.sel}, 32'h0);
      chk({tag, "_fml_do"}, 32'(fml_bus.dat_w), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
   endtask

   initial begin
      string exp_order;
      wb_rst_n = 1'b1;
      disp_stb = 1'b0; disp_adr = '0;
      cpu_stb = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_sel = '0; cpu_dw = '0;
      #2 wb_rst_n = 1'b0;
      #2 check_all_zero("reset");
      repeat (2) @(posedge wb_clk);
      #1 wb_rst_n = 1'b1;
      @(posedge wb_clk); #1;

      // display read, 3-cycle FML latency
      slv_fixed = 1; slv_lat = 3; slv_data = 16'hA55A;
      disp_req(17'h00010, 25'h00B8020, 16'hA55A, 1'b0, 3);

      // CPU read, then CPU byte write at the top word of the window
      slv_lat = 2; slv_data = 16'hBEEF;
      cpu_req(17'h00005, 1'b0, 2'b01, 16'h0000, 25'h00B800A, 16'hBEEF, 2);
      slv_lat = 3; slv_data = 16'hDEAD;
      cpu_req(17'h1FFFF, 1'b1, 2'b10, 16'h1234, 25'h00F7FFE, 16'hBEEF, 3);

      // both requesters continuously, latency 1: DDDDC groups
      slv_fixed = 0; slv_lat = 1;
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               logic [24:0] ea;
               ea = byte_adr(17'h00100 + 17'(i));
               disp_req(17'h00100 + 17'(i), ea, ea[15:0] ^ 16'h5A5A, 1'b0, 1);
            end
         end
         begin
            for (int i = 0; i < 3; i++) begin
               logic [24:0] ea;
               ea = byte_adr(17'h00200 + 17'(i));
               cpu_req(17'h00200 + 17'(i), 1'b1, 2'b01, 16'hC000 + 16'(i), ea, 16'hBEEF, 1);
            end
         end
      join
      exp_order = "DDDDCDDDDCDDDDC";
      chk("grant_count", grant_log.size(), 15);
      for (int i = 0; i < 15 && i < grant_log.size(); i++)
         chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_order[i]));

      // watchdog abort after 8 strobe cycles, then a normal request
      slv_fixed = 1; slv_lat = 0;
      disp_req(17'h00020, 25'h00B8040, 16'hFFFF, 1'b1, 8);
      slv_lat = 3; slv_data = 16'h3C3C;
      disp_req(17'h00021, 25'h00B8042, 16'h3C3C, 1'b0, 3);

      // reset two cycles into a CPU write abandons it
      slv_data = 16'h9999;
      q_fml_c.push_back('{25'h00B8080, 1'b1, 2'b01, 16'h7777, 0});
      cpu_adr = 17'h00040; cpu_we = 1'b1; cpu_sel = 2'b01; cpu_dw = 16'h7777;
      cpu_stb = 1'b1;
      @(posedge wb_clk); #1;
      @(posedge wb_clk); #1;
      @(posedge wb_clk); #1;
      wb_rst_n = 1'b0;
      #1 check_all_zero("midtxn_reset");
      cpu_stb = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1 wb_rst_n = 1'b1;
      repeat (12) @(posedge wb_clk);
      #1;
      slv_data = 16'h0F0F;
      disp_req(17'h00003, 25'h00B8006, 16'h0F0F, 1'b0, 3);

      repeat (4) @(posedge wb_clk);
      chk("pending_fml_disp", q_fml_d.size(), 0);
      chk("pending_fml_cpu", q_fml_c.size(), 0);
      chk("pending_rsp_disp", q_rsp_d.size(), 0);
      chk("pending_rsp_cpu", q_rsp_c.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
